// File: rtl/io_entry_ctrl.sv
// Hex-digit entry controller driving a simple req/done memory port.
// Ports: clk, rst, key0/key1/sw buttons; mem_* request side;
//        mode_out, stage_out, disp_data status; io_done pulse.
module io_entry_ctrl #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16,
    parameter int NSW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key0,
    input  logic              key1,
    input  logic [NSW-1:0]    sw,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mode_out,
    output logic [3:0]        stage_out,
    output logic [4*NSW-1:0]  disp_data,
    output logic              io_done
);
    localparam int CW = 4 * NSW;
    localparam int NA = (ADDR_W + CW - 1) / CW;
    localparam int ND = (DATA_W + CW - 1) / CW;
    localparam int AP = NA * CW;
    localparam int DP = ND * CW;
    localparam int NI = NSW + 2;

    localparam logic [1:0] M_CLR = 2'b00;
    localparam logic [1:0] M_RD  = 2'b01;
    localparam logic [1:0] M_WR  = 2'b10;
    localparam logic [1:0] M_BSY = 2'b11;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_WRITE,
        S_READ,
        S_ASTG,
        S_DSTG,
        S_ISSUE,
        S_WAIT,
        S_SHOW
    } state_t;

    // Synchronizer and edge detector; flops reset high so a button
    // held through reset produces no event.
    logic [NI-1:0] s1_q, s2_q, prev_q;
    logic [NI-1:0] ev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '1;
            s2_q   <= '1;
            prev_q <= '1;
        end else begin
            s1_q   <= {sw, key1, key0};
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign ev = s2_q & ~prev_q;

    logic k0_ev, k1_ev;
    logic [NSW-1:0] sw_ev;

    assign k0_ev = ev[0];
    assign k1_ev = ev[1];
    assign sw_ev = ev[NI-1:2];

    // k_q is the entry-stage index, and the read chunk index in SHOW.
    state_t            state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [1:0]        md_q, md_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            k_q     <= '0;
            md_q    <= M_CLR;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            md_q    <= md_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Registers padded to whole chunks; incrementing a nibble of the
    // padded copy and truncating gives modulo-2^w per digit, and
    // digits lying entirely in the padding drop out.
    logic [AP-1:0] a_pad, a_inc;
    logic [DP-1:0] d_pad, d_inc, r_pad;
    int            base;

    always_comb begin
        a_pad = AP'(addr_q);
        d_pad = DP'(wdata_q);
        r_pad = DP'(rdata_q);
        base  = int'(k_q) * CW;
        a_inc = a_pad;
        d_inc = d_pad;
        for (int i = 0; i < NSW; i++) begin
            if (sw_ev[i]) begin
                a_inc[base+4*i +: 4] = a_pad[base+4*i +: 4] + 4'd1;
                d_inc[base+4*i +: 4] = d_pad[base+4*i +: 4] + 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        md_d    = md_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                if (k0_ev) begin
                    state_d = S_WRITE;
                    md_d    = M_WR;
                end else if (k1_ev) begin
                    addr_d  = '0;
                    wdata_d = '0;
                    rdata_d = '0;
                    done_d  = 1'b1;
                end
            end
            S_WRITE: begin
                if (k0_ev) begin
                    state_d = S_READ;
                    md_d    = M_RD;
                end else if (k1_ev) begin
                    state_d = S_ASTG;
                    k_d     = '0;
                end
            end
            S_READ: begin
                if (k0_ev) begin
                    state_d = S_CLEAR;
                    md_d    = M_CLR;
                end else if (k1_ev) begin
                    state_d = S_ASTG;
                    k_d     = '0;
                end
            end
            S_ASTG: begin
                if (k0_ev) begin
                    state_d = (md_q == M_WR) ? S_WRITE : S_READ;
                end else if (k1_ev) begin
                    if (k_q != 4'(NA - 1)) begin
                        k_d = k_q + 4'd1;
                    end else if (md_q == M_WR) begin
                        state_d = S_DSTG;
                        k_d     = '0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    addr_d = a_inc[ADDR_W-1:0];
                end
            end
            S_DSTG: begin
                if (k0_ev) begin
                    state_d = S_WRITE;
                end else if (k1_ev) begin
                    if (k_q != 4'(ND - 1)) begin
                        k_d = k_q + 4'd1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    wdata_d = d_inc[DATA_W-1:0];
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    done_d = 1'b1;
                    if (md_q == M_WR) begin
                        state_d = S_WRITE;
                    end else begin
                        rdata_d = mem_rdata;
                        state_d = S_SHOW;
                        k_d     = '0;
                    end
                end
            end
            S_SHOW: begin
                if (k0_ev) begin
                    state_d = S_READ;
                end else if (k1_ev) begin
                    if (k_q == 4'(ND - 1)) begin
                        state_d = S_READ;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        mode_out  = md_q;
        stage_out = 4'd0;
        disp_data = '0;
        unique case (state_q)
            S_ASTG: begin
                stage_out = k_q + 4'd1;
                disp_data = a_pad[base +: CW];
            end
            S_DSTG: begin
                stage_out = 4'(NA) + k_q + 4'd1;
                disp_data = d_pad[base +: CW];
            end
            S_ISSUE, S_WAIT: begin
                mode_out  = M_BSY;
                stage_out = 4'd15;
            end
            S_SHOW: begin
                mode_out  = M_BSY;
                stage_out = 4'd15;
                disp_data = r_pad[base +: CW];
            end
            default: begin
                mode_out = md_q;
            end
        endcase
    end

    assign mem_req   = (state_q == S_ISSUE);
    assign mem_we    = (md_q == M_WR);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign io_done   = done_q;

endmodule
